// File: rtl/zjh_seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Holds the scan state enum, the 4511-style segment patterns and the
// helpers that map a digit number onto its nibble inside the BCD word.
package zjh_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // All segments off; used for the inter-digit gap and non-BCD codes.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment patterns {a,b,c,d,e,f,g} for digits 0..9.
    localparam logic [6:0] SEG_PATTERNS [0:9] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h1F, 7'h70, 7'h7F, 7'h73
    };

    // Bit position of the least significant bit of digit i's nibble.
    function automatic int nibble_lsb(input int i);
        return 4 * i;
    endfunction

    // Bit position of the most significant bit of digit i's nibble.
    function automatic int nibble_msb(input int i);
        return 4 * i + 3;
    endfunction

endpackage

// File: rtl/zjh_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder, 4511 compatible:
// codes 10..15 turn every segment off instead of showing a glyph.
module zjh_bcd_to_seg
    import zjh_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Look up the pattern for valid BCD, blank anything above 9.
    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) begin
            seg = SEG_PATTERNS[bcd];
        end
    end

endmodule

// File: rtl/zjh_seg_scan.sv
// Multiplexed common-cathode seven-segment scanner.
// A load strobe captures bcd_in into a pending buffer; the pending word is
// moved into the active (displayed) buffer only at the frame wrap, so a
// frame never mixes old and new digits. Each digit is lit SCAN_DIV cycles
// followed by a single blank cycle to suppress ghosting.
// Optional build macro: ZJH_SEG_LZB_EN enables leading-zero blanking.
module zjh_seg_scan
    import zjh_seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  Clk,
    input  logic                  MR,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [4*DIGITS-1:0]   pending_reg;
    logic [4*DIGITS-1:0]   active_reg, active_next;
    logic [6:0]            seg_reg, seg_next;
    logic [DIGITS-1:0]     dig_en_reg, dig_en_next;
    logic                  frame_done_reg, frame_done_next;

    logic [3:0]            digit_val [DIGITS];
    logic [DIGITS-1:0]     digit_onehot;
    logic [6:0]            dec_seg;
    logic                  lz_blank;

    // Split the active word into digits and decode the scan index.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_val[gi]    = active_reg[nibble_lsb(gi) +: 4];
            assign digit_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef ZJH_SEG_LZB_EN
    // zero_above[i] is set when digit i and every higher digit are zero.
    logic [DIGITS:0]   zero_above;
    logic [DIGITS-1:0] lz_digit;
    assign zero_above[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
            assign zero_above[gi] = (digit_val[gi] == 4'd0) && zero_above[gi+1];
            // Digit 0 is always decoded so a zero value still reads "0".
            if (gi == 0) begin : g_first
                assign lz_digit[gi] = 1'b0;
            end else begin : g_upper
                assign lz_digit[gi] = zero_above[gi];
            end
        end
    endgenerate
    assign lz_blank = |(lz_digit & digit_onehot);
`else
    assign lz_blank = 1'b0;
`endif

    // The active buffer only changes on the edge into BLANK, so whenever the
    // next state is SHOW this decode already reflects the next cycle's digit.
    zjh_bcd_to_seg u_dec (
        .bcd (digit_val[idx_reg]),
        .seg (dec_seg)
    );

    // Next-state, counter, buffer transfer and registered-output logic.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        active_next     = active_reg;
        frame_done_next = 1'b0;
        seg_next        = SEG_BLANK;
        dig_en_next     = '0;

        unique case (state_reg)
            BLANK: begin
                state_next = SHOW;
                cnt_next   = '0;
            end
            SHOW: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (idx_reg == IDX_LAST) begin
                        idx_next        = '0;
                        frame_done_next = 1'b1;
                        // A load on the wrap edge goes straight to the display.
                        active_next     = load ? bcd_in : pending_reg;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
            end
        endcase

        // Segments and enable are derived together so they always switch as a pair.
        if (state_next == SHOW) begin
            seg_next    = lz_blank ? SEG_BLANK : dec_seg;
            dig_en_next = digit_onehot;
        end
    end

    // Scanner state, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (MR) begin
            state_reg      <= BLANK;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            active_reg     <= '0;
            seg_reg        <= SEG_BLANK;
            dig_en_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            active_reg     <= active_next;
            seg_reg        <= seg_next;
            dig_en_reg     <= dig_en_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Pending buffer: captures bcd_in on any load strobe.
    always_ff @(posedge Clk) begin
        if (MR) begin
            pending_reg <= '0;
        end else if (load) begin
            pending_reg <= bcd_in;
        end
    end

    assign seg        = seg_reg;
    assign dig_en     = dig_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_zjh_seg_scan.sv
// Scoreboard bench for zjh_seg_scan with DIGITS=4, SCAN_DIV=4.
// Each frame pushes its 20 expected {frame_done, dig_en, seg} words; every
// cycle one word is popped and compared with the DUT outputs.
module tb_zjh_seg_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        Clk;
    logic        MR;
    logic [15:0] bcd_in;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q [$];

    zjh_seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .Clk        (Clk),
        .MR         (MR),
        .bcd_in     (bcd_in),
        .load       (load),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h1F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h73;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] shown, input int d);
        logic [15:0] upper;
        logic [6:0]  s;
        s = seg_of(shown[4*d +: 4]);
        upper = shown >> (4 * d);
`ifdef ZJH_SEG_LZB_EN
        if (d > 0 && upper == 16'h0000) s = 7'h00;
`else
        if (upper == 16'hFFFF) s = 7'h00; // no nibble pattern can reach this
`endif
        return s;
    endfunction

    // Push one frame's expectations, then step cycles 0..last_cyc comparing
    // outputs and driving load during cycle load_cyc (-1 = no load).
    task automatic run_frame(input int fnum, input logic [15:0] shown,
                             input int load_cyc, input logic [15:0] load_val,
                             input int last_cyc);
        logic [11:0] e;
        logic [3:0]  onehot;
        for (int d = 0; d < DIGITS; d++) begin
            onehot = 4'b0001 << d;
            for (int k = 0; k < SCAN_DIV; k++) begin
                exp_q.push_back({1'b0, onehot, exp_seg(shown, d)});
            end
            exp_q.push_back({(d == DIGITS - 1), 4'b0000, 7'h00});
        end
        for (int c = 0; c <= last_cyc; c++) begin
            @(negedge Clk);
            if (exp_q.size() == 0) begin
                check_eq($sformatf("f%0d_c%0d_underrun", fnum, c), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("f%0d_c%0d", fnum, c), {20'd0, frame_done, dig_en, seg}, {20'd0, e});
            end
            if (c == load_cyc) begin
                load   = 1'b1;
                bcd_in = load_val;
            end else begin
                load   = 1'b0;
            end
        end
        $display("frame %0d expected_shown=%h cycles=%0d load_cyc=%0d load_val=%h",
                 fnum, shown, last_cyc + 1, load_cyc, load_val);
    endtask

    initial begin
        MR     = 1'b1;
        load   = 1'b0;
        bcd_in = 16'h0000;

        repeat (3) begin
            @(negedge Clk);
            check_eq("reset_outputs", {20'd0, frame_done, dig_en, seg}, 32'd0);
        end
        MR = 1'b0;

        run_frame(0, 16'h0000, 5,  16'h1234, 19);
        run_frame(1, 16'h1234, 18, 16'h00A9, 19);   // load on the wrap edge
        run_frame(2, 16'h00A9, 19, 16'h0050, 19);   // load just after the wrap
        run_frame(3, 16'h00A9, -1, 16'h0000, 19);
        run_frame(4, 16'h0050, 2,  16'h9876, 19);
        run_frame(5, 16'h9876, 3,  16'h5555, 11);   // stop while idx 2 is lit

        exp_q.delete();
        MR = 1'b1;
        @(negedge Clk);
        check_eq("mr_mid_show", {20'd0, frame_done, dig_en, seg}, 32'd0);
        MR = 1'b0;

        run_frame(6, 16'h0000, -1, 16'h0000, 19);
        run_frame(7, 16'h0000, -1, 16'h0000, 19);   // pending 5555 was discarded

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
